// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM state
// encoding and the clocks-per-bit computation.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_IGN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic int calc_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered pointers; an extra pointer MSB separates
// full from empty. A write to a full FIFO is accepted only alongside a read.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Head is forced to zero when empty so the unreset storage never shows.
  assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with 3-point majority sampling, parity/frame tagging and an
// output FIFO. Optional break detection is enabled by UART_RX_BREAK_DET_EN.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BODE_RATE  = 10_000_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    rx_ctrl,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_data_valid,
  input  logic                          rx_data_ready,
  output logic [1:0]                    rx_err,
  output logic                          rx_overrun,
  input  logic                          rx_err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                          rx_break
`endif
);

  localparam int CPB  = calc_cpb(CLK_FREQ, BODE_RATE);
  localparam int CW   = $clog2(CPB);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int SMP0 = CPB / 2 - 1;
  localparam int SMP1 = CPB / 2;
  localparam int SMP2 = CPB / 2 + 1;
  localparam int FW   = DATA_BITS + 2;
  // Loading 1 instead of 0 absorbs part of the synchroniser delay so the
  // sample points sit near the bit centre even at CPB = 4.
  localparam logic [CW-1:0] CNT_LOAD = CW'(1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           ctrl_q;
  logic                 par_err_q, frame_err_q;
  logic                 fall, vote_pt, bit_val, cnt_last, push;
  logic                 fifo_full, fifo_empty, pop;
  logic [FW-1:0]        fifo_rd;
`ifdef UART_RX_BREAK_DET_EN
  logic                 seen_one_q, brk;
`endif

  assign fall     = rx_prev & ~rx_sync;
  assign cnt_last = (cnt_q == CW'(CPB - 1));
  assign vote_pt  = (state_q != ST_IDLE) && (state_q != ST_BREAK) && (cnt_q == CW'(SMP2));
  assign bit_val  = majority3(s0_q, s1_q, rx_sync);
  assign rx_busy  = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (vote_pt) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (vote_pt && idx_q == IW'(DATA_BITS - 1))
                   state_d = (ctrl_q != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (vote_pt) state_d = ST_STOP;
      ST_STOP: begin
        if (vote_pt && idx_q == IW'(STOP_BITS - 1)) begin
          state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (!seen_one_q && !bit_val) begin
            state_d = ST_BREAK;
            brk     = 1'b1;
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end
      end
      ST_BREAK:  if (rx_sync && cnt_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      shift_q     <= '0;
      ctrl_q      <= PAR_NONE;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      unique case (state_q)
        ST_IDLE:  cnt_q <= CNT_LOAD;
        ST_BREAK: cnt_q <= (!rx_sync || cnt_last) ? '0 : cnt_q + 1'b1;
        default:  cnt_q <= (cnt_last || state_d == ST_BREAK) ? '0 : cnt_q + 1'b1;
      endcase

      if (state_d != state_q) idx_q <= '0;
      else if (vote_pt)       idx_q <= idx_q + 1'b1;

      if (cnt_q == CW'(SMP0)) s0_q <= rx_sync;
      if (cnt_q == CW'(SMP1)) s1_q <= rx_sync;

      if (state_q == ST_IDLE && fall) begin
        ctrl_q      <= rx_ctrl;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      if (vote_pt && state_q == ST_DATA) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};

      if (vote_pt && state_q == ST_PARITY) begin
        unique case (ctrl_q)
          PAR_EVEN: par_err_q <= ^{shift_q, bit_val};
          PAR_ODD:  par_err_q <= ~^{shift_q, bit_val};
          default:  par_err_q <= 1'b0;
        endcase
      end

      if (vote_pt && state_q == ST_STOP && !bit_val) frame_err_q <= 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_one_q <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      rx_break <= brk;
      if (state_q == ST_IDLE && fall) seen_one_q <= 1'b0;
      else if (vote_pt && state_q != ST_START && bit_val) seen_one_q <= 1'b1;
    end
  end
`endif

  assign pop = rx_data_valid & rx_data_ready;

  // Overrun: a push finds the FIFO full with no pop to free a slot; set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            rx_overrun <= 1'b0;
    else if (push && fifo_full && !pop)  rx_overrun <= 1'b1;
    else if (rx_err_clr)                 rx_overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (push),
    .wr_data ({frame_err_q | ~bit_val, par_err_q, shift_q}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (rx_level)
  );

  assign rx_data_valid = !fifo_empty;
  assign rx_data       = fifo_rd[DATA_BITS-1:0];
  assign rx_err        = fifo_rd[FW-1 -: 2];

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf at CPB = 10 (100 MHz clock, 10 Mbaud), 8N1
// unless a test selects parity.
module tb_uart_rx_buf;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] rx_ctrl;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [1:0] rx_err;
  logic       rx_overrun;
  logic       rx_err_clr;
  logic [3:0] rx_level;
  logic       rx_busy;
`ifdef UART_RX_BREAK_DET_EN
  logic       rx_break;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_buf dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_ctrl       (rx_ctrl),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_err        (rx_err),
    .rx_overrun    (rx_overrun),
    .rx_err_clr    (rx_err_clr),
    .rx_level      (rx_level),
    .rx_busy       (rx_busy)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .rx_break      (rx_break)
`endif
  );

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic p,
                            input logic stop, input logic flip_ctrl);
    send_bit(1'b0);
    if (flip_ctrl) rx_ctrl = 2'b00;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(p);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx = 1'b1; rx_ctrl = 2'b00; rx_data_ready = 1'b0; rx_err_clr = 1'b0;
    #30;
    n_vec++;
    if ({rx_data, rx_data_valid, rx_err} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_head got %h want 000", {rx_data, rx_data_valid, rx_err});
    end
    n_vec++;
    if ({rx_overrun, rx_level, rx_busy} !== 6'h00) begin
      n_err++;
      $display("FAIL reset_status got %h want 00", {rx_overrun, rx_level, rx_busy});
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({rx_data_valid, rx_level, rx_busy} !== 6'h00) begin
      n_err++;
      $display("FAIL reset_idle got %h want 00", {rx_data_valid, rx_level, rx_busy});
    end
  endtask

  task automatic test_basic();
    rx_ctrl = 2'b00;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({rx_data_valid, rx_err, rx_data, rx_level} !== {1'b1, 2'b00, 8'h55, 4'd1}) begin
      n_err++;
      $display("FAIL basic_55 got v=%b e=%b d=%h l=%0d want v=1 e=00 d=55 l=1",
               rx_data_valid, rx_err, rx_data, rx_level);
    end
    pop_one();
    n_vec++;
    if ({rx_data_valid, rx_level} !== 5'b0_0000) begin
      n_err++;
      $display("FAIL basic_pop got v=%b l=%0d want v=0 l=0", rx_data_valid, rx_level);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d   [6] = '{8'h33, 8'h33, 8'hF0, 8'h22, 8'h22, 8'h33};
    logic [1:0] ctl [6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
    logic       p   [6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       flp [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [1:0] exp [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      rx_ctrl = ctl[i];
      send_frame(d[i], 1'b1, p[i], 1'b1, flp[i]);
      n_vec++;
      if ({rx_data_valid, rx_err, rx_data, rx_level} !== {1'b1, exp[i], d[i], 4'd1}) begin
        n_err++;
        $display("FAIL parity_%0d got v=%b e=%b d=%h l=%0d want v=1 e=%b d=%h l=1",
                 i, rx_data_valid, rx_err, rx_data, rx_level, exp[i], d[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_frame_err();
    rx_ctrl = 2'b00;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({rx_data_valid, rx_err, rx_data} !== {1'b1, 2'b10, 8'hA5}) begin
      n_err++;
      $display("FAIL frame_err got v=%b e=%b d=%h want v=1 e=10 d=a5",
               rx_data_valid, rx_err, rx_data);
    end
    pop_one();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy_rise got %b want 1", rx_busy);
    end
    repeat (7) @(posedge clk);
    #1;
    n_vec++;
    if ({rx_busy, rx_data_valid, rx_level} !== 6'b0_0_0000) begin
      n_err++;
      $display("FAIL glitch_idle got busy=%b v=%b l=%0d want busy=0 v=0 l=0",
               rx_busy, rx_data_valid, rx_level);
    end
  endtask

  task automatic test_reset_mid_frame();
    rx_ctrl = 2'b00;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    #30;
    rst = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    n_vec++;
    if ({rx_busy, rx_data_valid, rx_level} !== 6'b0_0_0000) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b v=%b l=%0d want busy=0 v=0 l=0",
               rx_busy, rx_data_valid, rx_level);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({rx_data_valid, rx_err, rx_data, rx_level} !== {1'b1, 2'b00, 8'h3C, 4'd1}) begin
      n_err++;
      $display("FAIL reset_recover got v=%b e=%b d=%h l=%0d want v=1 e=00 d=3c l=1",
               rx_data_valid, rx_err, rx_data, rx_level);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    rx_ctrl = 2'b00;
    rx_data_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    n_vec++;
    if ({rx_level, rx_overrun, rx_data} !== {4'd8, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL overrun got l=%0d ovr=%b d=%h want l=8 ovr=1 d=10",
               rx_level, rx_overrun, rx_data);
    end
    rx_err_clr = 1'b1;
    @(posedge clk);
    #1;
    rx_err_clr = 1'b0;
    n_vec++;
    if ({rx_overrun, rx_level} !== {1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL overrun_clr got ovr=%b l=%0d want ovr=0 l=8", rx_overrun, rx_level);
    end
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      n_vec++;
      if ({rx_data_valid, rx_data} !== {1'b1, d}) begin
        n_err++;
        $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, rx_data_valid, rx_data, d);
      end
      pop_one();
    end
    n_vec++;
    if ({rx_data_valid, rx_level, rx_overrun} !== 6'b0_0000_0) begin
      n_err++;
      $display("FAIL drain_empty got v=%b l=%0d ovr=%b want v=0 l=0 ovr=0",
               rx_data_valid, rx_level, rx_overrun);
    end
  endtask

`ifdef UART_RX_BREAK_DET_EN
  task automatic test_break();
    int pulses = 0;
    rx = 1'b0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(posedge clk);
      #1;
      if (rx_break === 1'b1) pulses++;
    end
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    n_vec++;
    if ({pulses[3:0], rx_level, rx_busy} !== {4'd1, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL break got pulses=%0d l=%0d busy=%b want pulses=1 l=0 busy=0",
               pulses, rx_level, rx_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
`ifdef UART_RX_BREAK_DET_EN
    test_break();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
